// File: rtl/huff_decoder.sv
// huff_decoder: serial Huffman decoder.
// The host loads internal-node entries while idle. In decode mode the block
// walks the tree from the root, one code bit per handshake, and presents the
// 5-bit symbol index whenever it reaches a leaf.
// Optional build macro HUFF_SYMCOUNT_EN adds the sym_count output, a running
// count of accepted symbols.
//
// state | meaning
// IDLE  | tree-load mode, walk position held at root
// WALK  | accepting code bits and descending the tree
// EMIT  | symbol presented, waiting for downstream to take it
module huff_decoder #(
  parameter int NODES     = 31,
  parameter int MAX_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        decode_en,
  input  logic        tree_we,
  input  logic [4:0]  tree_addr,
  input  logic [11:0] tree_data,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [4:0]  sym_out,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        err
`ifdef HUFF_SYMCOUNT_EN
  ,
  output logic [15:0] sym_count
`endif
);

  localparam int              DW      = $clog2(MAX_DEPTH) + 1;
  localparam logic [5:0]      NODES_W = 6'(NODES);
  localparam logic [DW-1:0]   MAXD_W  = DW'(MAX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cur_q, cur_d;
  logic [DW-1:0]   depth_q, depth_d, depth_inc;
  logic [4:0]      sym_q, sym_d;
  logic            sym_valid_q, sym_valid_d;
  logic            err_q, err_d;
  logic [11:0]     tree_q [NODES];
  logic [11:0]     node;
  logic [5:0]      child;
  logic            xfer;

  // Tree store: writable only while idle in tree-load mode, in-range addresses only
  always_ff @(posedge CLK) begin
    if (tree_we && !decode_en && (state_q == S_IDLE) && ({1'b0, tree_addr} < NODES_W))
      tree_q[tree_addr] <= tree_data;
  end

  // Child selected by the incoming bit: right field on 1, left field on 0
  assign node      = tree_q[cur_q];
  assign child     = bit_in ? node[5:0] : node[11:6];
  assign depth_inc = depth_q + DW'(1);
  assign xfer      = bit_ready && bit_valid;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath-next logic for the tree walk
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    depth_d     = depth_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cur_d   = '0;
        depth_d = '0;
        if (decode_en) state_d = S_WALK;
      end
      S_WALK: begin
        if (xfer) begin
          if (child[5]) begin
            sym_d       = child[4:0];
            sym_valid_d = 1'b1;
            cur_d       = '0;
            depth_d     = '0;
            state_d     = S_EMIT;
          end else if (({1'b0, child[4:0]} < NODES_W) && (depth_inc < MAXD_W)) begin
            cur_d   = child[4:0];
            depth_d = depth_inc;
          end else begin
            // Broken pointer or over-long code: drop the partial code, restart at root
            err_d   = 1'b1;
            cur_d   = '0;
            depth_d = '0;
          end
        end else if (!decode_en) begin
          cur_d   = '0;
          depth_d = '0;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
          state_d     = decode_en ? S_WALK : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: bits are only accepted while walking in decode mode
  always_comb begin
    bit_ready = (state_q == S_WALK) && decode_en;
  end

  // Walk position, symbol holding register and error pulse
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_q       <= '0;
      depth_q     <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      depth_q     <= depth_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      err_q       <= err_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign err       = err_q;

`ifdef HUFF_SYMCOUNT_EN
  logic        de_q;
  logic [15:0] cnt_q;

  // Symbol counter: restarts on each new decode session, wraps at 16 bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      de_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      de_q <= decode_en;
      if (decode_en && !de_q)            cnt_q <= '0;
      else if (sym_valid_q && sym_ready) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sym_count = cnt_q;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// tb_huff_decoder: directed bench for huff_decoder with a tree-walk reference
// model and a per-cycle compare process.
module tb_huff_decoder;
  localparam int NODES     = 31;
  localparam int MAX_DEPTH = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        decode_en = 1'b0;
  logic        tree_we = 1'b0;
  logic [4:0]  tree_addr = '0;
  logic [11:0] tree_data = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        sym_ready = 1'b0;
  logic        bit_ready;
  logic [4:0]  sym_out;
  logic        sym_valid;
  logic        err;
`ifdef HUFF_SYMCOUNT_EN
  logic [15:0] sym_count;
`endif

  always #5 CLK = ~CLK;

  huff_decoder #(.NODES(NODES), .MAX_DEPTH(MAX_DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .decode_en(decode_en),
    .tree_we(tree_we), .tree_addr(tree_addr), .tree_data(tree_data),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .err(err)
`ifdef HUFF_SYMCOUNT_EN
    , .sym_count(sym_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input bit ok, input int act, input int exp_v);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // Reference model: software tree walk over a copy of the loaded tree
  logic [11:0] m_tree [NODES];
  int          m_cur = 0;
  int          m_depth = 0;
  bit          m_de_last = 1'b0;
  bit          m_exp_err = 1'b0;
  int          exp_q[$];
  int          log_q[$];
  int          err_seen = 0;

  function automatic void model_step(input logic b);
    logic [11:0] e;
    logic [5:0]  c;
    e = m_tree[m_cur];
    c = b ? e[5:0] : e[11:6];
    if (c[5]) begin
      exp_q.push_back(int'(c[4:0]));
      m_cur = 0; m_depth = 0;
    end else if (int'(c[4:0]) < NODES && m_depth + 1 < MAX_DEPTH) begin
      m_cur = int'(c[4:0]); m_depth++;
    end else begin
      m_exp_err = 1'b1;
      m_cur = 0; m_depth = 0;
    end
  endfunction

  // Model update on each clock edge from the pre-edge inputs and handshakes
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exp_q.delete();
      m_cur = 0; m_depth = 0; m_de_last = 1'b0; m_exp_err = 1'b0;
    end else begin
      m_exp_err = 1'b0;
      if (tree_we && !decode_en && int'(tree_addr) < NODES) m_tree[tree_addr] = tree_data;
      if (sym_valid && sym_ready) begin
        log_q.push_back(int'(sym_out));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bit_valid && bit_ready) model_step(bit_in);
      if (!decode_en) begin m_cur = 0; m_depth = 0; end
      m_de_last = decode_en;
    end
  end

  // Per-cycle compare against the model, mid-cycle
  always @(negedge CLK) begin
    if (nRST) begin
      check("err", err === m_exp_err, int'(err), int'(m_exp_err));
      check("sym_valid", sym_valid === (exp_q.size() != 0), int'(sym_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("sym_out", int'(sym_out) == exp_q[0], int'(sym_out), exp_q[0]);
      check("bit_ready", bit_ready === (decode_en && m_de_last && exp_q.size() == 0),
            int'(bit_ready), int'(decode_en && m_de_last && exp_q.size() == 0));
      if (err) err_seen++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic write_node(input logic [4:0] a, input logic [11:0] d);
    tree_addr = a; tree_data = d; tree_we = 1'b1;
    tick();
    tree_we = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_in = b; bit_valid = 1'b1;
    #1;
    while (!bit_ready && n < 50) begin
      @(posedge CLK); #2;
      n++;
    end
    check("bit_accept", bit_ready, int'(bit_ready), 1);
    if (bit_ready) begin @(posedge CLK); #2; end
    bit_valid = 1'b0;
  endtask

  function automatic int last_sym();
    return (log_q.size() > 0) ? log_q[$] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n0;
    // Reset values
    tick(2);
    check("rst_sym_out", sym_out == 5'd0, int'(sym_out), 0);
    check("rst_sym_valid", sym_valid == 1'b0, int'(sym_valid), 0);
    check("rst_err", err == 1'b0, int'(err), 0);
    check("rst_bit_ready", bit_ready == 1'b0, int'(bit_ready), 0);
    nRST = 1'b1;
    tick(2);

    // node0 = {leaf 3, internal 1}, node1 = {leaf 7, leaf 9}
    write_node(5'd0, 12'b1_00011_0_00001);
    write_node(5'd1, 12'b1_00111_1_01001);
    write_node(5'd31, 12'hFFF);

    // Bits 0,1,0,1,1 -> 3, 7, 9
    sym_ready = 1'b1;
    decode_en = 1'b1;
    e0 = err_seen;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    tick(3);
    check("seq_count", log_q.size() == 3, log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("seq_sym0", log_q[0] == 3, log_q[0], 3);
      check("seq_sym1", log_q[1] == 7, log_q[1], 7);
      check("seq_sym2", log_q[2] == 9, log_q[2], 9);
    end
    check("seq_no_err", err_seen == e0, err_seen, e0);

    // Backpressure: symbol 9 held for 5 cycles
    sym_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", sym_valid == 1'b1, int'(sym_valid), 1);
      check("hold_sym", sym_out == 5'd9, int'(sym_out), 9);
      check("hold_ready", bit_ready == 1'b0, int'(bit_ready), 0);
      tick();
    end
    sym_ready = 1'b1;
    tick();
    check("after_hold_ready", bit_ready == 1'b1, int'(bit_ready), 1);
    send_bit(1'b0);
    tick(2);
    check("after_hold_sym", last_sym() == 3, last_sym(), 3);

    // Self-loop at node1: error after the 16th bit, then decoding resumes
    decode_en = 1'b0;
    tick(2);
    write_node(5'd1, 12'b1_00111_0_00001);
    decode_en = 1'b1;
    e0 = err_seen;
    repeat (15) send_bit(1'b1);
    check("depth_no_err_yet", err_seen == e0, err_seen, e0);
    send_bit(1'b1);
    check("depth_err", err == 1'b1, int'(err), 1);
    tick();
    check("depth_err_pulse", err == 1'b0, int'(err), 0);
    check("depth_err_once", err_seen == e0 + 1, err_seen, e0 + 1);
    send_bit(1'b0);
    tick(2);
    check("depth_recover", last_sym() == 3, last_sym(), 3);

    // Write while decoding is dropped; partial code is discarded on decode_en drop
    write_node(5'd0, 12'b1_00101_1_00110);
    send_bit(1'b1);
    decode_en = 1'b0;
    tick(2);
    decode_en = 1'b1;
    send_bit(1'b0);
    tick(2);
    check("ignored_write", last_sym() == 3, last_sym(), 3);

    // Out-of-range internal pointer
    decode_en = 1'b0;
    tick(2);
    write_node(5'd0, 12'b1_00011_0_11111);
    decode_en = 1'b1;
    n0 = log_q.size();
    send_bit(1'b1);
    check("range_err", err == 1'b1, int'(err), 1);
    tick(2);
    check("range_no_sym", log_q.size() == n0, log_q.size(), n0);
    send_bit(1'b0);
    tick(2);
    check("range_recover", last_sym() == 3, last_sym(), 3);

    // Async reset during EMIT
    sym_ready = 1'b0;
    send_bit(1'b0);
    check("emit_before_rst", sym_valid == 1'b1, int'(sym_valid), 1);
    nRST = 1'b0;
    #1;
    check("rst_emit_valid", sym_valid == 1'b0, int'(sym_valid), 0);
    check("rst_emit_ready", bit_ready == 1'b0, int'(bit_ready), 0);
    check("rst_emit_sym", sym_out == 5'd0, int'(sym_out), 0);
    tick();
    nRST = 1'b1;
    sym_ready = 1'b1;
    decode_en = 1'b0;
    tick(2);
    write_node(5'd0, 12'b1_00011_0_00001);
    write_node(5'd1, 12'b1_00111_1_01001);
    decode_en = 1'b1;
`ifdef HUFF_SYMCOUNT_EN
    tick();
    check("cnt_start", sym_count == 16'd0, int'(sym_count), 0);
`endif
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    tick(3);
    check("post_rst_sym", last_sym() == 3, last_sym(), 3);
`ifdef HUFF_SYMCOUNT_EN
    check("cnt_three", sym_count == 16'd3, int'(sym_count), 3);
    decode_en = 1'b0;
    tick(2);
    check("cnt_held", sym_count == 16'd3, int'(sym_count), 3);
    decode_en = 1'b1;
    tick();
    check("cnt_clear", sym_count == 16'd0, int'(sym_count), 0);
`endif
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
